counter_3_checker: RTL and testbench

Sequence checker for the 3-bit ripple/sync counter's Q1..Q3 outputs: the receiving end of the counter's output interface. It samples the count each enabled clock and verifies that every sample equals the previous sample plus one, modulo 8. It acquires lock after a run of correct increments, then flags, counts and recovers from sequence errors. It sits beside the counter in lab builds and benches as a self-checking monitor that can also be synthesized to drive LEDs.

---
 rtl/counter_3_checker_if.sv | 11 +
 rtl/counter_3_checker.sv | 116 +++++++++++
 tb/tb_counter_3_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/counter_3_checker_if.sv
// Output bundle of the 3-bit counter: sample enable plus the Q1..Q3 count bits.
// The counter drives it through the master modport and the checker reads it through the slave modport.
interface counter_3_checker_if;
    logic en;
    logic Q1;
    logic Q2;
    logic Q3;

    modport master (output en, output Q1, output Q2, output Q3);
    modport slave  (input  en, input  Q1, input  Q2, input  Q3);
endinterface

// File: rtl/counter_3_checker.sv
// Sequence checker for a 3-bit counter: it acquires lock on a run of +1 increments,
// then flags and counts sequence errors and drops lock after repeated errors.
module counter_3_checker #(
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_3_checker_if.slave   cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [2:0]           last_count,
    output logic [2:0]           expected
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]           LOCK_TGT   = 4'(LOCK_COUNT);
    localparam logic [3:0]           UNLOCK_TGT = 4'(UNLOCK_ERRS);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE    = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_t               state, state_n;
    logic [3:0]           run, run_n;
    logic [3:0]           bad, bad_n;
    logic [2:0]           last_n;
    logic [ERR_CNT_W-1:0] cnt_n;
    logic                 err_n, wrap_n;
    logic [2:0]           sample;
    logic [3:0]           run_inc, bad_inc;
    logic                 match;

    assign sample   = {cnt.Q3, cnt.Q2, cnt.Q1};
    assign expected = last_count + 3'd1;
    assign match    = (sample == expected);
    assign run_inc  = run + 4'd1;
    assign bad_inc  = bad + 4'd1;
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n = state;
        run_n   = run;
        bad_n   = bad;
        last_n  = last_count;
        cnt_n   = err_count;
        err_n   = 1'b0;
        wrap_n  = 1'b0;
        if (cnt.en) begin
            // Always resynchronize to the newest sample, whatever the verdict.
            last_n = sample;
            unique case (state)
                EMPTY: begin
                    run_n   = 4'd0;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        run_n = run_inc;
                        if (run_inc == LOCK_TGT) begin
                            state_n = LOCKED;
                            bad_n   = 4'd0;
                        end
                    end else begin
                        run_n = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_n  = 4'd0;
                        wrap_n = (last_count == 3'd7) && (sample == 3'd0);
                    end else begin
                        err_n = 1'b1;
                        if (err_count != {ERR_CNT_W{1'b1}}) begin
                            cnt_n = err_count + CNT_ONE;
                        end
                        bad_n = bad_inc;
                        if (bad_inc == UNLOCK_TGT) begin
                            state_n = ACQUIRE;
                            run_n   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            run        <= 4'd0;
            bad        <= 4'd0;
            last_count <= 3'd0;
            err_count  <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            run        <= run_n;
            bad        <= bad_n;
            last_count <= last_n;
            err_count  <= cnt_n;
            err_pulse  <= err_n;
            wrap_pulse <= wrap_n;
        end
    end

endmodule

// File: tb/tb_counter_3_checker.sv
// Directed bench for counter_3_checker: default-parameter instance for lock, errors, gaps and reset,
// plus a narrow-counter instance for saturation.
module tb_counter_3_checker;

    logic       clk;
    logic       rst;
    int         total_checks;
    int         bad_checks;

    logic       locked, err_pulse, wrap_pulse;
    logic [7:0] err_count;
    logic [2:0] last_count, expected;

    logic       s_locked, s_err_pulse, s_wrap_pulse;
    logic [1:0] s_err_count;
    logic [2:0] s_last_count, s_expected;

    counter_3_checker_if cif ();
    counter_3_checker_if sif ();

    counter_3_checker dut (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cif.slave),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .last_count (last_count),
        .expected   (expected)
    );

    counter_3_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(15), .ERR_CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .cnt        (sif.slave),
        .locked     (s_locked),
        .err_pulse  (s_err_pulse),
        .wrap_pulse (s_wrap_pulse),
        .err_count  (s_err_count),
        .last_count (s_last_count),
        .expected   (s_expected)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic doReset(input int cycles, input logic e, input logic [2:0] v);
        @(negedge clk);
        rst    = 1'b1;
        cif.en = e;
        {cif.Q3, cif.Q2, cif.Q1} = v;
        repeat (cycles) @(posedge clk);
        #1;
        checkOutput("rst.locked", 32'(locked), 32'd0);
        checkOutput("rst.err_pulse", 32'(err_pulse), 32'd0);
        checkOutput("rst.wrap_pulse", 32'(wrap_pulse), 32'd0);
        checkOutput("rst.err_count", 32'(err_count), 32'd0);
        checkOutput("rst.last_count", 32'(last_count), 32'd0);
        checkOutput("rst.expected", 32'(expected), 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        cif.en = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic e, input logic [2:0] v,
                                 input logic x_locked, input logic x_err, input logic x_wrap,
                                 input logic [7:0] x_cnt, input logic [2:0] x_last);
        logic [2:0] x_exp;
        @(negedge clk);
        cif.en = e;
        {cif.Q3, cif.Q2, cif.Q1} = v;
        @(posedge clk);
        #1;
        x_exp = x_last + 3'd1;
        checkOutput({tag, ".locked"}, 32'(locked), 32'(x_locked));
        checkOutput({tag, ".err_pulse"}, 32'(err_pulse), 32'(x_err));
        checkOutput({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(x_wrap));
        checkOutput({tag, ".err_count"}, 32'(err_count), 32'(x_cnt));
        checkOutput({tag, ".last_count"}, 32'(last_count), 32'(x_last));
        checkOutput({tag, ".expected"}, 32'(expected), 32'(x_exp));
    endtask

    task automatic applySat(input string tag, input logic [2:0] v, input logic x_locked,
                            input logic x_err, input logic [1:0] x_cnt);
        @(negedge clk);
        sif.en = 1'b1;
        {sif.Q3, sif.Q2, sif.Q1} = v;
        @(posedge clk);
        #1;
        checkOutput({tag, ".locked"}, 32'(s_locked), 32'(x_locked));
        checkOutput({tag, ".err_pulse"}, 32'(s_err_pulse), 32'(x_err));
        checkOutput({tag, ".err_count"}, 32'(s_err_count), 32'(x_cnt));
        checkOutput({tag, ".last_count"}, 32'(s_last_count), 32'(v));
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        total_checks = 0;
        bad_checks   = 0;
        cif.en = 1'b0; cif.Q1 = 1'b0; cif.Q2 = 1'b0; cif.Q3 = 1'b0;
        sif.en = 1'b0; sif.Q1 = 1'b0; sif.Q2 = 1'b0; sif.Q3 = 1'b0;

        // Clean count 0..7,0,1: lock after the fifth sample, one wrap after 7->0.
        doReset(2, 1'b0, 3'd0);
        applyStimulus("clean0", 1, 3'd0, 0, 0, 0, 8'd0, 3'd0);
        applyStimulus("clean1", 1, 3'd1, 0, 0, 0, 8'd0, 3'd1);
        applyStimulus("clean2", 1, 3'd2, 0, 0, 0, 8'd0, 3'd2);
        applyStimulus("clean3", 1, 3'd3, 0, 0, 0, 8'd0, 3'd3);
        applyStimulus("clean4", 1, 3'd4, 1, 0, 0, 8'd0, 3'd4);
        applyStimulus("clean5", 1, 3'd5, 1, 0, 0, 8'd0, 3'd5);
        applyStimulus("clean6", 1, 3'd6, 1, 0, 0, 8'd0, 3'd6);
        applyStimulus("clean7", 1, 3'd7, 1, 0, 0, 8'd0, 3'd7);
        applyStimulus("clean0w", 1, 3'd0, 1, 0, 1, 8'd0, 3'd0);
        applyStimulus("clean1b", 1, 3'd1, 1, 0, 0, 8'd0, 3'd1);

        // Single skip 6->0 while locked: one error, lock kept, next 1 matches.
        applyStimulus("skip2", 1, 3'd2, 1, 0, 0, 8'd0, 3'd2);
        applyStimulus("skip3", 1, 3'd3, 1, 0, 0, 8'd0, 3'd3);
        applyStimulus("skip4", 1, 3'd4, 1, 0, 0, 8'd0, 3'd4);
        applyStimulus("skip5", 1, 3'd5, 1, 0, 0, 8'd0, 3'd5);
        applyStimulus("skip6", 1, 3'd6, 1, 0, 0, 8'd0, 3'd6);
        applyStimulus("skip0", 1, 3'd0, 1, 1, 0, 8'd1, 3'd0);
        applyStimulus("skip1", 1, 3'd1, 1, 0, 0, 8'd1, 3'd1);

        // Unlock on two errors, then reacquire after four good increments.
        doReset(1, 1'b0, 3'd0);
        applyStimulus("unl0", 1, 3'd0, 0, 0, 0, 8'd0, 3'd0);
        applyStimulus("unl1", 1, 3'd1, 0, 0, 0, 8'd0, 3'd1);
        applyStimulus("unl2", 1, 3'd2, 0, 0, 0, 8'd0, 3'd2);
        applyStimulus("unl3", 1, 3'd3, 0, 0, 0, 8'd0, 3'd3);
        applyStimulus("unl4", 1, 3'd4, 1, 0, 0, 8'd0, 3'd4);
        applyStimulus("unl3a", 1, 3'd3, 1, 1, 0, 8'd1, 3'd3);
        applyStimulus("unl3b", 1, 3'd3, 0, 1, 0, 8'd2, 3'd3);
        applyStimulus("unl3c", 1, 3'd3, 0, 0, 0, 8'd2, 3'd3);
        applyStimulus("unl4b", 1, 3'd4, 0, 0, 0, 8'd2, 3'd4);
        applyStimulus("unl5", 1, 3'd5, 0, 0, 0, 8'd2, 3'd5);
        applyStimulus("unl6", 1, 3'd6, 0, 0, 0, 8'd2, 3'd6);
        applyStimulus("unl7", 1, 3'd7, 1, 0, 0, 8'd2, 3'd7);
        applyStimulus("unl0w", 1, 3'd0, 1, 0, 1, 8'd2, 3'd0);

        // en gap between 2 and 3 while locked: state held, no error; then reset with en high.
        applyStimulus("gap1", 1, 3'd1, 1, 0, 0, 8'd2, 3'd1);
        applyStimulus("gap2", 1, 3'd2, 1, 0, 0, 8'd2, 3'd2);
        applyStimulus("gapA", 0, 3'd5, 1, 0, 0, 8'd2, 3'd2);
        applyStimulus("gapB", 0, 3'd6, 1, 0, 0, 8'd2, 3'd2);
        applyStimulus("gapC", 0, 3'd0, 1, 0, 0, 8'd2, 3'd2);
        applyStimulus("gap3", 1, 3'd3, 1, 0, 0, 8'd2, 3'd3);
        doReset(1, 1'b1, 3'd4);

        // Acquire noise: the 5 restarts the run, lock after the final 1.
        applyStimulus("noise0", 1, 3'd0, 0, 0, 0, 8'd0, 3'd0);
        applyStimulus("noise1", 1, 3'd1, 0, 0, 0, 8'd0, 3'd1);
        applyStimulus("noise2", 1, 3'd2, 0, 0, 0, 8'd0, 3'd2);
        applyStimulus("noise5", 1, 3'd5, 0, 0, 0, 8'd0, 3'd5);
        applyStimulus("noise6", 1, 3'd6, 0, 0, 0, 8'd0, 3'd6);
        applyStimulus("noise7", 1, 3'd7, 0, 0, 0, 8'd0, 3'd7);
        applyStimulus("noise0b", 1, 3'd0, 0, 0, 0, 8'd0, 3'd0);
        applyStimulus("noise1b", 1, 3'd1, 1, 0, 0, 8'd0, 3'd1);

        // Saturation on a 2-bit error counter with a high unlock threshold.
        doReset(1, 1'b0, 3'd0);
        checkOutput("sat.rst.err_count", 32'(s_err_count), 32'd0);
        checkOutput("sat.rst.locked", 32'(s_locked), 32'd0);
        applySat("sat0", 3'd0, 0, 0, 2'd0);
        applySat("sat1", 3'd1, 0, 0, 2'd0);
        applySat("sat2", 3'd2, 0, 0, 2'd0);
        applySat("sat3", 3'd3, 0, 0, 2'd0);
        applySat("sat4", 3'd4, 1, 0, 2'd0);
        applySat("satE1", 3'd4, 1, 1, 2'd1);
        applySat("satE2", 3'd4, 1, 1, 2'd2);
        applySat("satE3", 3'd4, 1, 1, 2'd3);
        applySat("satE4", 3'd4, 1, 1, 2'd3);
        applySat("satE5", 3'd4, 1, 1, 2'd3);
        applySat("sat5", 3'd5, 1, 0, 2'd3);
        checkOutput("sat.wrap_pulse", 32'(s_wrap_pulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
